vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

- Sequences the horizontal and vertical pixel counters of the VGA display path.
- Generates hsync, vsync, the active-video window, the current pixel coordinates and line/frame strobes.
- Includes a run/stop controller, so the display engine can start scanning on request and stop cleanly at a frame boundary.
- Sits between the system clock/reset and the pixel-generation and colour-output logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- PIX_DIV, 4, system clocks per pixel (used only with VGA_PIX_DIV_EN)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  run request (level)
- pix_tick  out  1  pixel-advance enable
- x  out  CNT_W  horizontal count, 0..H_TOTAL-1
- y  out  CNT_W  vertical count, 0..V_TOTAL-1
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  high inside the visible window
- line_start  out  1  one-clk pulse, new line
- frame_start  out  1  one-clk pulse, new frame
- busy  out  1  high in RUN or DRAIN

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Control FSM states:
  - IDLE: counters held at 0.
  - RUN: counters advance; en=0 goes to DRAIN.
  - DRAIN: counters advance; en=1 returns to RUN with no counter disturbance.
  - IDLE -> RUN: on the edge where en=1.
  - DRAIN -> IDLE: on the pix_tick that wraps (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - A frame is therefore never truncated by en.
- Counters: all updates happen on edges where pix_tick=1.
  - x increments and wraps at H_TOTAL-1 to 0.
  - y increments only when x wraps, and wraps at V_TOTAL-1 to 0.
- Decode (registered, aligned with x/y in the same cycle):
  - hsync=0 iff H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vsync=0 iff V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC (490..491).
  - video_on=1 iff x<H_ACTIVE and y<V_ACTIVE, and the FSM is not IDLE.
- Strobes:
  - line_start is high for exactly one clk, the first cycle x=0 is presented.
  - frame_start is high for exactly one clk, the first cycle (x,y)=(0,0) is presented.
  - Both fire on the IDLE->RUN entry and on every wrap.
  - Neither fires on the wrap that enters IDLE.
- IDLE outputs: pix_tick=0, x=y=0, hsync=vsync=1, video_on=0, strobes 0, busy=0.

## Timing
- Reset assertion immediately forces:
  - state IDLE
  - x=0, y=0, divider=0
  - hsync=1, vsync=1
  - video_on=0, pix_tick=0, line_start=0, frame_start=0, busy=0
- The first edge with reset high and en=1 enters RUN: busy=1, frame_start=1, line_start=1 in the following cycle.
- Start latency is 1 clk from en sampled high to the first visible pixel (0,0) with video_on=1.
- Reset mid-frame aborts the frame with no drain.
- en toggling within one frame has no effect other than RUN/DRAIN membership; only the level at the final wrap matters.

## Configuration
- VGA_PIX_DIV_EN defined:
  - A mod-PIX_DIV divider runs in RUN/DRAIN and is cleared in IDLE.
  - pix_tick=1 on the cycle the divider equals PIX_DIV-1.
  - The first pix_tick after entering RUN is PIX_DIV clks later.
  - Strobes stay one clk wide although the counters hold for PIX_DIV clks.
- VGA_PIX_DIV_EN undefined:
  - No divider; pix_tick=1 every clk in RUN/DRAIN.
  - PIX_DIV is ignored.

## Test plan
- Reset release, en=0 for 50 clks -> x=y=0, hsync=vsync=1, video_on=0, busy=0 throughout.
- en=1, no macro -> frame_start pulse 1 clk after start; hsync low exactly for x=656..751 (96 clks per line); line period 800 clks; vsync low for y=490..491; frame period 420000 clks.
- With VGA_PIX_DIV_EN, PIX_DIV=4 -> pix_tick period 4 clks; line period 3200 clks; x holds each value 4 clks; line_start is 1 clk wide.
- en dropped at (x=100,y=200) -> scan continues to (799,524); busy falls on the wrap; no frame_start on that wrap; x=y=0 afterwards.
- en dropped then re-raised before the frame end -> no gap; the next frame_start occurs exactly 420000 clks after the previous one.
- reset asserted at (x=300,y=100) -> all outputs take reset values asynchronously, before the next clk edge; after release with en=1 the scan restarts at (0,0).

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel counters, sync/active-window decode, line/frame strobes and a run/drain controller.
// Define VGA_PIX_DIV_EN to advance pixels only every PIX_DIV system clocks; otherwise one pixel per clock.
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned PIX_DIV  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             pix_tick,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_start,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    if (PIX_DIV < 1) begin : g_bad_div
        $error("PIX_DIV must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] x_n;
    logic [CNT_W-1:0] y_n;
    logic             tick_n;
    logic             ls_n;
    logic             fs_n;
    logic             x_last;
    logic             y_last;
    logic             wrap;

`ifdef VGA_PIX_DIV_EN
    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_n;
`endif

    // Next-state, counter advance and strobe generation
    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        ls_n    = 1'b0;
        fs_n    = 1'b0;
`ifdef VGA_PIX_DIV_EN
        div_n   = div;
`endif
        x_last  = (x == CNT_W'(H_TOTAL - 1));
        y_last  = (y == CNT_W'(V_TOTAL - 1));
        wrap    = pix_tick && x_last && y_last;

        case (state)
            IDLE: begin
                if (en) begin
                    state_n = RUN;
                    x_n     = '0;
                    y_n     = '0;
                    ls_n    = 1'b1;
                    fs_n    = 1'b1;
`ifdef VGA_PIX_DIV_EN
                    div_n   = '0;
`endif
                end
            end
            RUN, DRAIN: begin
                state_n = en ? RUN : DRAIN;
`ifdef VGA_PIX_DIV_EN
                div_n = (div == DIV_W'(PIX_DIV - 1)) ? '0 : div + DIV_W'(1);
`endif
                if (pix_tick) begin
                    if (x_last) begin
                        x_n  = '0;
                        ls_n = 1'b1;
                        if (y_last) begin
                            y_n  = '0;
                            fs_n = 1'b1;
                        end else begin
                            y_n = y + CNT_W'(1);
                        end
                    end else begin
                        x_n = x + CNT_W'(1);
                    end
                end
                // The level of en at the frame wrap decides whether scanning continues
                if (wrap && !en) begin
                    state_n = IDLE;
                    x_n     = '0;
                    y_n     = '0;
                    ls_n    = 1'b0;
                    fs_n    = 1'b0;
`ifdef VGA_PIX_DIV_EN
                    div_n   = '0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef VGA_PIX_DIV_EN
        tick_n = (state_n != IDLE) && (div_n == DIV_W'(PIX_DIV - 1));
`else
        tick_n = (state_n != IDLE);
`endif
    end

    // State, counters and decoded outputs, all aligned to the presented x/y
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            pix_tick    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
`ifdef VGA_PIX_DIV_EN
            div         <= '0;
`endif
        end else begin
            state       <= state_n;
            x           <= x_n;
            y           <= y_n;
            pix_tick    <= tick_n;
            hsync       <= !((x_n >= CNT_W'(HS_BEG)) && (x_n < CNT_W'(HS_END)));
            vsync       <= !((y_n >= CNT_W'(VS_BEG)) && (y_n < CNT_W'(VS_END)));
            video_on    <= (state_n != IDLE) && (x_n < CNT_W'(H_ACTIVE)) && (y_n < CNT_W'(V_ACTIVE));
            line_start  <= ls_n;
            frame_start <= fs_n;
            busy        <= (state_n != IDLE);
`ifdef VGA_PIX_DIV_EN
            div         <= div_n;
`endif
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: small raster, directed + random run requests against a frame-position model.
module tb_vga_timing_ctrl;

    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int unsigned CW = 10, PD = 3;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FT = HT * VT;
`ifdef VGA_PIX_DIV_EN
    localparam int unsigned D = PD;
`else
    localparam int unsigned D = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          pix_tick;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hsync, vsync, video_on, line_start, frame_start, busy;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CNT_W(CW), .PIX_DIV(PD)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .pix_tick(pix_tick),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .line_start(line_start), .frame_start(frame_start), .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_fs = -1;

    // Model: running flag, linear pixel index within the frame, divider phase, strobes
    bit m_run = 1'b0;
    int m_p   = 0;
    int m_ph  = 0;
    bit m_ls  = 1'b0;
    bit m_fs  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit adv;
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (!reset) begin
            m_run = 1'b0; m_p = 0; m_ph = 0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1'b1; m_p = 0; m_ph = 0; m_ls = 1'b1; m_fs = 1'b1;
            end
        end else begin
            adv  = (m_ph == int'(D) - 1);
            m_ph = (m_ph + 1) % int'(D);
            if (adv) begin
                if (m_p == int'(FT) - 1) begin
                    if (en) begin
                        m_p = 0; m_ls = 1'b1; m_fs = 1'b1;
                    end else begin
                        m_run = 1'b0; m_p = 0; m_ph = 0;
                    end
                end else begin
                    m_p++;
                    if (m_p % int'(HT) == 0) m_ls = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        int ex, ey;
        ex = m_p % int'(HT);
        ey = m_p / int'(HT);
        chk("x", 32'(x), 32'(ex));
        chk("y", 32'(y), 32'(ey));
        chk("hsync", 32'(hsync), 32'(!(ex >= int'(HA + HF) && ex < int'(HA + HF + HS))));
        chk("vsync", 32'(vsync), 32'(!(ey >= int'(VA + VF) && ey < int'(VA + VF + VS))));
        chk("video_on", 32'(video_on), 32'(m_run && ex < int'(HA) && ey < int'(VA)));
        chk("busy", 32'(busy), 32'(m_run));
        chk("pix_tick", 32'(pix_tick), 32'(m_run && m_ph == int'(D) - 1));
        chk("line_start", 32'(line_start), 32'(m_ls));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) chk("frame_period", 32'(cyc - last_fs), 32'(FT * D));
            last_fs = cyc;
        end
        if (!m_run) last_fs = -1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pos(input int px, input int py);
        bit found;
        found = 1'b0;
        for (int i = 0; i < int'(4 * FT * D); i++) begin
            if (m_run && m_p == py * int'(HT) + px && m_ph == 0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("wait_pos_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        check_outputs();
        run(3);

        // Released, no run request: must stay idle
        reset = 1'b1;
        run(50);

        // Start and scan several whole frames
        en = 1'b1;
        step();
        chk("start_video_on", 32'(video_on), 32'd1);
        chk("start_frame_start", 32'(frame_start), 32'd1);
        run(int'(2 * FT * D) + 20);

        // Drop the request mid-frame: frame completes, then idle
        wait_pos(5, 3);
        en = 1'b0;
        run(int'(FT * D));
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_x", 32'(x), 32'd0);
        run(10);

        // Drop and re-raise within one frame: no gap between frames
        en = 1'b1;
        run(5);
        wait_pos(4, 2);
        en = 1'b0;
        run(20 * int'(D));
        en = 1'b1;
        run(int'(2 * FT * D));

        // Random run requests, mostly high then mostly low
        for (int i = 0; i < int'(3 * FT * D); i++) begin
            en = ($urandom_range(0, 9) != 0);
            step();
        end
        for (int i = 0; i < int'(2 * FT * D); i++) begin
            en = ($urandom_range(0, 3) == 0);
            step();
        end

        // Asynchronous reset mid-frame, then restart
        en = 1'b1;
        run(3);
        wait_pos(7, 4);
        reset = 1'b0;
        #1;
        m_run = 1'b0; m_p = 0; m_ph = 0; m_ls = 1'b0; m_fs = 1'b0;
        check_outputs();
        @(negedge clk);
        run(2);
        reset = 1'b1;
        step();
        chk("restart_frame_start", 32'(frame_start), 32'd1);
        run(int'(FT * D) + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
